vga_timing_controller: RTL

Generates the VGA raster timing that drives the pixel-colour logic. It produces the horizCount/vertCount pixel counters consumed by the graphics generator. It takes back that block's combinational red/green/blue, then blanks and registers it together with hsync/vsync so that colour and sync leave the chip aligned. It also exports pixel, line and frame strobes so game-state logic can update between frames.

---
 rtl/vga_timing_controller.sv | 94 +++++++++
 1 files changed

// File: rtl/vga_timing_controller.sv
// vga_timing_controller: VGA raster counters, pixel/line/frame strobes and a blanked RGB/sync output stage
module vga_timing_controller #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] redIn,
  input  logic [3:0] greenIn,
  input  logic [3:0] blueIn,
  output logic [9:0] horizCount,
  output logic [9:0] vertCount,
  output logic       pixelTick,
  output logic       lineTick,
  output logic       frameTick,
  output logic       hsync,
  output logic       vsync,
  output logic       videoOn,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] HS_B = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_E = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_B = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_E = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  logic [3:0] div;
  logic       active, hs, vs;
  // region decode from the current, pre-increment counts
  always_comb begin
    active = horizCount < H_ACT && vertCount < V_ACT;
    hs = horizCount >= HS_B && horizCount <= HS_E;
    vs = vertCount >= VS_B && vertCount <= VS_E;
  end
  // pixel divider; the strobe is registered so it is low in reset and follows the wrap by one clk
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div       <= 4'd0;
      pixelTick <= 1'b0;
    end else begin
      div       <= div == DIV_LAST ? 4'd0 : div + 4'd1;
      pixelTick <= div == DIV_LAST;
    end
  end
  // raster counters with line/frame strobes raised on the wrapping edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      horizCount <= 10'd0;
      vertCount  <= 10'd0;
      lineTick   <= 1'b0;
      frameTick  <= 1'b0;
    end else begin
      lineTick  <= pixelTick && horizCount == H_LAST;
      frameTick <= pixelTick && horizCount == H_LAST && vertCount == V_LAST;
      if (pixelTick) begin
        horizCount <= horizCount == H_LAST ? 10'd0 : horizCount + 10'd1;
        if (horizCount == H_LAST) vertCount <= vertCount == V_LAST ? 10'd0 : vertCount + 10'd1;
      end
    end
  end
  // shared output stage so sync and blanked colour leave aligned
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      videoOn <= 1'b0;
      hsync   <= ~SYNC_POL;
      vsync   <= ~SYNC_POL;
      red     <= 4'd0;
      green   <= 4'd0;
      blue    <= 4'd0;
    end else if (pixelTick) begin
      videoOn <= active;
      hsync   <= hs ? SYNC_POL : ~SYNC_POL;
      vsync   <= vs ? SYNC_POL : ~SYNC_POL;
      red     <= active ? redIn : 4'd0;
      green   <= active ? greenIn : 4'd0;
      blue    <= active ? blueIn : 4'd0;
    end
  end
endmodule
